// File: rtl/icache_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : icache_fetch_unit
// Description : Direct-mapped, read-only instruction cache for the IF stage.
//               A hit returns the instruction combinationally. A miss raises
//               BUSYWAIT, refills one 128-bit block from instruction memory
//               and then retries the access from IDLE.
// Ports       : CLK, RESET (async, active-high)
//               READ, ADDRESS[31:0]        - fetch request from the PC
//               INSTRUCTION[31:0], BUSYWAIT - result / stall to the pipeline
//               MEM_READ, MEM_BLOCK_ADDR[27:0], MEM_READDATA[127:0],
//               MEM_BUSYWAIT               - block refill handshake
//               HIT_COUNT, MISS_COUNT       - saturating performance counters
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fetch_unit #(
   parameter int INDEX_BITS = 3,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 READ,
   input  logic [31:0]          ADDRESS,
   output logic [31:0]          INSTRUCTION,
   output logic                 BUSYWAIT,
   output logic                 MEM_READ,
   output logic [27:0]          MEM_BLOCK_ADDR,
   input  logic [127:0]         MEM_READDATA,
   input  logic                 MEM_BUSYWAIT,
   output logic [CNT_WIDTH-1:0] HIT_COUNT,
   output logic [CNT_WIDTH-1:0] MISS_COUNT
);

   localparam int TAG_BITS   = 28 - INDEX_BITS;
   localparam int NUM_BLOCKS = 1 << INDEX_BITS;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_FETCH  = 2'd1;
   localparam logic [1:0] S_UPDATE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [NUM_BLOCKS-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0]   tag_q  [NUM_BLOCKS];
   logic [TAG_BITS-1:0]   tag_d  [NUM_BLOCKS];
   logic [127:0]          data_q [NUM_BLOCKS];
   logic [127:0]          data_d [NUM_BLOCKS];
   logic [27:0]           miss_block_q, miss_block_d;
   logic [127:0]          fill_q, fill_d;
   logic [CNT_WIDTH-1:0]  hit_cnt_q, hit_cnt_d;
   logic [CNT_WIDTH-1:0]  miss_cnt_q, miss_cnt_d;

   logic [1:0]            word_sel;
   logic [INDEX_BITS-1:0] index;
   logic [TAG_BITS-1:0]   tag;
   logic [INDEX_BITS-1:0] fill_index;
   logic [TAG_BITS-1:0]   fill_tag;
   logic [127:0]          cur_block;
   logic                  lookup_match;
   logic                  access_idle;
   logic                  hit;
   logic                  miss;
   logic                  addr_unused;

   assign word_sel   = ADDRESS[3:2];
   assign index      = ADDRESS[4 +: INDEX_BITS];
   assign tag        = ADDRESS[31 -: TAG_BITS];
   assign fill_index = miss_block_q[INDEX_BITS-1:0];
   assign fill_tag   = miss_block_q[27 -: TAG_BITS];
   assign cur_block  = data_q[index];
   // Byte offset within a word is irrelevant to an instruction fetch.
   assign addr_unused = ^ADDRESS[1:0];

   // Lookups are only evaluated in IDLE; RESET masks them so that all
   // outputs are quiet for as long as reset is held.
   assign lookup_match = valid_q[index] && (tag_q[index] == tag);
   assign access_idle  = !RESET && (state_q == S_IDLE) && READ;
   assign hit          = access_idle && lookup_match;
   assign miss         = access_idle && !lookup_match;

   // ---------------------------------------------------------------- state
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (miss)          state_d = S_FETCH;
         S_FETCH:  if (!MEM_BUSYWAIT) state_d = S_UPDATE;
         S_UPDATE:                    state_d = S_IDLE;
         default:                     state_d = S_IDLE;
      endcase
   end

   // -------------------------------------------------------------- outputs
   // FETCH and UPDATE stall unconditionally: the latched refill always
   // completes, whatever the PC does meanwhile.
   always_comb begin
      INSTRUCTION    = 32'h0;
      BUSYWAIT       = 1'b0;
      MEM_READ       = 1'b0;
      MEM_BLOCK_ADDR = 28'h0;
      if (!RESET) begin
         case (state_q)
            S_IDLE: begin
               BUSYWAIT = miss;
               if (hit) INSTRUCTION = cur_block[{word_sel, 5'b0} +: 32];
            end
            S_FETCH: begin
               MEM_READ       = 1'b1;
               MEM_BLOCK_ADDR = miss_block_q;
               BUSYWAIT       = 1'b1;
            end
            S_UPDATE: BUSYWAIT = 1'b1;
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------- datapath
   always_comb begin
      valid_d      = valid_q;
      tag_d        = tag_q;
      data_d       = data_q;
      miss_block_d = miss_block_q;
      fill_d       = fill_q;
      hit_cnt_d    = hit_cnt_q;
      miss_cnt_d   = miss_cnt_q;

      if (miss) begin
         miss_block_d = ADDRESS[31:4];
         if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
      end
      if (hit && (hit_cnt_q != '1)) hit_cnt_d = hit_cnt_q + CNT_ONE;

      // Memory data is valid in the same cycle MEM_BUSYWAIT drops.
      if ((state_q == S_FETCH) && !MEM_BUSYWAIT) fill_d = MEM_READDATA;

      if (state_q == S_UPDATE) begin
         valid_d[fill_index] = 1'b1;
         tag_d[fill_index]   = fill_tag;
         data_d[fill_index]  = fill_q;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         valid_q      <= '0;
         miss_block_q <= 28'h0;
         fill_q       <= 128'h0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         valid_q      <= valid_d;
         miss_block_q <= miss_block_d;
         fill_q       <= fill_d;
         hit_cnt_q    <= hit_cnt_d;
         miss_cnt_q   <= miss_cnt_d;
      end
   end

   // Tag and data arrays need no reset: the valid bits qualify them.
   always_ff @(posedge CLK) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign HIT_COUNT  = hit_cnt_q;
   assign MISS_COUNT = miss_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_icache_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fetch_unit
// Description : Self-checking bench for icache_fetch_unit. A table of fetches,
//               hand-written multi-cycle sequences and random fetches are
//               compared against a block-level cache model. A second instance
//               with 4-bit counters shares all stimulus to cover saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fetch_unit;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic         READ = 1'b0;
   logic [31:0]  ADDRESS = 32'h0;
   logic [31:0]  INSTRUCTION;
   logic         BUSYWAIT;
   logic         MEM_READ;
   logic [27:0]  MEM_BLOCK_ADDR;
   logic [127:0] MEM_READDATA;
   logic         MEM_BUSYWAIT;
   logic [31:0]  HIT_COUNT, MISS_COUNT;

   logic [31:0]  instr4;
   logic         busy4, mem_read4;
   logic [27:0]  blk_addr4;
   logic [3:0]   hit4, miss4;

   int n_chk  = 0;
   int n_fail = 0;
   int mem_lat = 1;
   int mem_cnt;

   // model state
   bit          mvalid [8];
   logic [27:0] mblk   [8];
   int          m_hit, m_miss;
   logic [27:0] fetch_q [$];

   typedef struct {
      logic [31:0] addr;
      int          lat;
      int          exp_hit;
   } vec_t;
   vec_t vecs [11];

   icache_fetch_unit #(.INDEX_BITS(3), .CNT_WIDTH(32)) dut (
      .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
      .INSTRUCTION(INSTRUCTION), .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ),
      .MEM_BLOCK_ADDR(MEM_BLOCK_ADDR), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(HIT_COUNT), .MISS_COUNT(MISS_COUNT)
   );

   icache_fetch_unit #(.INDEX_BITS(3), .CNT_WIDTH(4)) dut_sat (
      .CLK(CLK), .RESET(RESET), .READ(READ), .ADDRESS(ADDRESS),
      .INSTRUCTION(instr4), .BUSYWAIT(busy4), .MEM_READ(mem_read4),
      .MEM_BLOCK_ADDR(blk_addr4), .MEM_READDATA(MEM_READDATA),
      .MEM_BUSYWAIT(MEM_BUSYWAIT), .HIT_COUNT(hit4), .MISS_COUNT(miss4)
   );

   always #5 CLK = ~CLK;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] t;
      t = {2'b00, a[31:2]};
      return t * 32'h9E37_79B1 + 32'h1234_5678;
   endfunction

   // Instruction memory: data ready on the mem_lat-th cycle of a read.
   always @(posedge CLK or posedge RESET) begin
      if (RESET) mem_cnt <= 0;
      else       mem_cnt <= MEM_READ ? mem_cnt + 1 : 0;
   end
   assign MEM_BUSYWAIT = !(MEM_READ && (mem_cnt >= mem_lat - 1));
   assign MEM_READDATA = {mem_word({MEM_BLOCK_ADDR, 4'hC}), mem_word({MEM_BLOCK_ADDR, 4'h8}),
                          mem_word({MEM_BLOCK_ADDR, 4'h4}), mem_word({MEM_BLOCK_ADDR, 4'h0})};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic model_reset;
      for (int i = 0; i < 8; i++) mvalid[i] = 1'b0;
      m_hit  = 0;
      m_miss = 0;
   endtask

   task automatic install(input logic [31:0] a);
      mvalid[a[6:4]] = 1'b1;
      mblk[a[6:4]]   = a[31:4];
   endtask

   task automatic check_counts;
      chk("hit_count",      HIT_COUNT,  32'(m_hit));
      chk("miss_count",     MISS_COUNT, 32'(m_miss));
      chk("hit_count_sat",  32'(hit4),  32'((m_hit  > 15) ? 15 : m_hit));
      chk("miss_count_sat", 32'(miss4), 32'((m_miss > 15) ? 15 : m_miss));
   endtask

   // Runs while BUSYWAIT is high; records the block address of each
   // distinct memory read burst. Optionally changes ADDRESS mid-miss.
   task automatic run_miss(input int chg_at, input logic [31:0] chg_addr, output int busy);
      bit prev;
      busy = 0;
      prev = 1'b0;
      fetch_q.delete();
      while ((BUSYWAIT === 1'b1) && (busy < 400)) begin
         if (MEM_READ && !prev) fetch_q.push_back(MEM_BLOCK_ADDR);
         if (!MEM_READ) chk("idle_block_addr", 32'(MEM_BLOCK_ADDR), 32'h0);
         prev = MEM_READ;
         busy++;
         tick;
         if (busy == chg_at) ADDRESS = chg_addr;
         #2;
      end
      if (busy >= 400) chk("miss_timeout", 32'(busy), 32'h0);
   endtask

   task automatic access(input logic [31:0] a, input int lat, input int exp_hit);
      int busy;
      bit hit_e;
      hit_e = (exp_hit < 0) ? (mvalid[a[6:4]] && (mblk[a[6:4]] == a[31:4])) : (exp_hit != 0);
      mem_lat = lat;
      READ    = 1'b1;
      ADDRESS = a;
      #2;
      if (hit_e) begin
         chk("hit_busywait", 32'(BUSYWAIT), 32'h0);
         chk("hit_instr",    INSTRUCTION,   mem_word(a));
         chk("hit_mem_read", 32'(MEM_READ), 32'h0);
      end else begin
         chk("miss_busywait_now", 32'(BUSYWAIT), 32'h1);
         run_miss(0, 32'h0, busy);
         chk("miss_penalty", 32'(busy), 32'(lat + 2));
         chk("refill_bursts", 32'(fetch_q.size()), 32'h1);
         if (fetch_q.size() > 0) chk("refill_block", 32'(fetch_q[0]), 32'(a[31:4]));
         chk("miss_instr", INSTRUCTION, mem_word(a));
         install(a);
         m_miss++;
      end
      tick;
      m_hit++;
      check_counts();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy;
      vecs[0]  = '{32'h0000_0000, 5, 0};
      vecs[1]  = '{32'h0000_0004, 1, 1};
      vecs[2]  = '{32'h0000_0008, 1, 1};
      vecs[3]  = '{32'h0000_000C, 1, 1};
      vecs[4]  = '{32'h0000_0080, 3, 0};
      vecs[5]  = '{32'h0000_0000, 2, 0};
      vecs[6]  = '{32'h0000_0010, 1, 0};
      vecs[7]  = '{32'h0000_0014, 1, 1};
      vecs[8]  = '{32'h0000_0004, 1, 1};
      vecs[9]  = '{32'h0000_001C, 1, 1};
      vecs[10] = '{32'h0000_0084, 4, 0};
      model_reset();

      // reset state, with READ high to show outputs stay quiet
      repeat (2) tick;
      READ = 1'b1;
      #2;
      chk("rst_busywait", 32'(BUSYWAIT), 32'h0);
      chk("rst_mem_read", 32'(MEM_READ), 32'h0);
      chk("rst_instr",    INSTRUCTION,   32'h0);
      check_counts();
      tick;
      RESET = 1'b0;

      // table: cold miss, same-block hits, conflict misses
      for (int i = 0; i < 11; i++) begin
         access(vecs[i].addr, vecs[i].lat, vecs[i].exp_hit);
         if (i == 3) begin
            chk("t2_hit_count",  HIT_COUNT,  32'd4);
            chk("t2_miss_count", MISS_COUNT, 32'd1);
         end
         if (i == 5) chk("t3_miss_count", MISS_COUNT, 32'd3);
      end

      // READ=0: quiet outputs, no state change
      READ = 1'b0;
      ADDRESS = 32'h0000_0300;
      #2;
      chk("read0_busywait", 32'(BUSYWAIT), 32'h0);
      chk("read0_instr",    INSTRUCTION,   32'h0);
      tick;
      #2;
      chk("read0_mem_read", 32'(MEM_READ), 32'h0);
      check_counts();

      // address change during FETCH: 0x100 refill completes, then 0x200 misses
      mem_lat = 5;
      READ = 1'b1;
      ADDRESS = 32'h0000_0100;
      #2;
      run_miss(2, 32'h0000_0200, busy);
      chk("chg_penalty", 32'(busy), 32'd14);
      chk("chg_bursts",  32'(fetch_q.size()), 32'd2);
      if (fetch_q.size() > 1) begin
         chk("chg_block0", 32'(fetch_q[0]), 32'h10);
         chk("chg_block1", 32'(fetch_q[1]), 32'h20);
      end
      chk("chg_instr", INSTRUCTION, mem_word(32'h0000_0200));
      install(32'h0000_0100);
      install(32'h0000_0200);
      m_miss += 2;
      tick;
      m_hit++;
      check_counts();

      // reset two cycles into a miss
      mem_lat = 5;
      ADDRESS = 32'h0000_0000;
      #2;
      chk("rmf_busywait", 32'(BUSYWAIT), 32'h1);
      tick;
      #2;
      chk("rmf_fetch1", 32'(MEM_READ), 32'h1);
      tick;
      #2;
      chk("rmf_fetch2", 32'(MEM_READ), 32'h1);
      RESET = 1'b1;
      #1;
      chk("rmf_mem_read",   32'(MEM_READ),       32'h0);
      chk("rmf_busywait0",  32'(BUSYWAIT),       32'h0);
      chk("rmf_block_addr", 32'(MEM_BLOCK_ADDR), 32'h0);
      chk("rmf_instr",      INSTRUCTION,         32'h0);
      model_reset();
      check_counts();
      tick;
      RESET = 1'b0;
      access(32'h0000_0000, 3, 0);

      // random fetches against the model
      for (int i = 0; i < 200; i++) begin
         logic [31:0] a;
         if ($urandom_range(0, 7) == 0) begin
            READ = 1'b0;
            ADDRESS = $urandom;
            #2;
            chk("rnd_read0_busywait", 32'(BUSYWAIT), 32'h0);
            chk("rnd_read0_instr",    INSTRUCTION,   32'h0);
            tick;
            check_counts();
         end else begin
            a = ($urandom_range(0, 23) << 4) | $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) a = a | 32'hF000_0000;
            access(a, int'($urandom_range(1, 4)), -1);
         end
      end

      // saturation of the 4-bit counters
      access(32'h0000_0040, 2, -1);
      repeat (20) access(32'h0000_0044, 1, 1);
      chk("sat_hit_hold", 32'(hit4), 32'hF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
